// File: rtl/perf_counter_ctrl.sv
// Purpose : bank of NUM_EVENTS rising-edge event counters with a shadow snapshot
//           bank, serialised behind one four-phase req/ack host port.
// Latency : READ/SNAPSHOT/CLEAR_ONE ack 2 edges after req is sampled; CLEAR_ALL
//           acks NUM_EVENTS+2 edges after. An event edge reaches its counter 1 edge after it is sampled.
// Backpressure: the host holds req until ack. ack is held until req drops, and
//           busy stays high until then. Event inputs are never back-pressured.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   event_in  per-event level lines, one count per 0->1 transition
//   count_en  global count enable; edges seen while low are dropped
//   req       host request (four-phase)
//   cmd       00 READ, 01 SNAPSHOT, 10 CLEAR_ONE, 11 CLEAR_ALL (sampled with req)
//   addr      counter index for READ / CLEAR_ONE (sampled with req)
//   ack       command complete, held until req drops
//   busy      high whenever the controller is not idle
//   rdata     READ result (shadow bank), held until the next READ completes
//   ovf       sticky per-counter saturation flag
//
// Build option: define PERF_SATURATE_EN to make counters saturate at all-ones and
// raise a sticky ovf bit. Without it, counters wrap and ovf is tied to 0.

module perf_counter_ctrl #(
  parameter int NUM_EVENTS = 4,
  parameter int WIDTH      = 10,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  count_en,
  input  logic                  req,
  input  logic [1:0]            cmd,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      rdata,
  output logic [NUM_EVENTS-1:0] ovf
);

  typedef enum logic [1:0] {
    CMD_READ      = 2'b00,
    CMD_SNAPSHOT  = 2'b01,
    CMD_CLEAR_ONE = 2'b10,
    CMD_CLEAR_ALL = 2'b11
  } cmd_e;

  // SETUP sits between IDLE and EXEC. It registers the shadow read mux and the
  // one-hot clear mask from the latched address, so EXEC only does a plain load.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EXEC,
    S_SWEEP,
    S_ACK
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_EVENTS - 1);

  state_t state;
  state_t next_state;

  cmd_e                  cmd_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     idx;
  logic [NUM_EVENTS-1:0] clr_mask_q;
  logic [WIDTH-1:0]      rd_pend;

  logic [NUM_EVENTS-1:0] ev_prev;
  logic [NUM_EVENTS-1:0] rise_q;

  logic [WIDTH-1:0]      count  [NUM_EVENTS];
  logic [WIDTH-1:0]      shadow [NUM_EVENTS];

  // FSM decode outputs
  logic                  latch_cmd;
  logic                  do_setup;
  logic                  do_read;
  logic                  do_snap;
  logic                  do_clr_one;
  logic                  do_sweep;
  logic                  sweep_start;

  // Datapath selects derived from the latched address / sweep index
  logic [WIDTH-1:0]      rd_sel;
  logic [NUM_EVENTS-1:0] addr_onehot;
  logic [NUM_EVENTS-1:0] clr_vec;

  // ---------------------------------------------------------------------------
  // Event edge detection. The detected rise is registered once before it
  // reaches the counter, which keeps the wide increment off the input path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_prev <= '0;
      rise_q  <= '0;
    end else begin
      ev_prev <= event_in;
      rise_q  <= event_in & ~ev_prev & {NUM_EVENTS{count_en}};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    ack         = 1'b0;
    busy        = 1'b1;
    latch_cmd   = 1'b0;
    do_setup    = 1'b0;
    do_read     = 1'b0;
    do_snap     = 1'b0;
    do_clr_one  = 1'b0;
    do_sweep    = 1'b0;
    sweep_start = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          latch_cmd  = 1'b1;
          next_state = S_SETUP;
        end
      end

      S_SETUP: begin
        do_setup   = 1'b1;
        next_state = S_EXEC;
      end

      S_EXEC: begin
        case (cmd_q)
          CMD_READ: begin
            do_read    = 1'b1;
            next_state = S_ACK;
          end
          CMD_SNAPSHOT: begin
            do_snap    = 1'b1;
            next_state = S_ACK;
          end
          CMD_CLEAR_ONE: begin
            do_clr_one = 1'b1;
            next_state = S_ACK;
          end
          CMD_CLEAR_ALL: begin
            sweep_start = 1'b1;
            next_state  = S_SWEEP;
          end
        endcase
      end

      S_SWEEP: begin
        do_sweep = 1'b1;
        if (idx == LAST_IDX) begin
          next_state = S_ACK;
        end
      end

      S_ACK: begin
        ack = 1'b1;
        if (!req) begin
          next_state = S_IDLE;
        end
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode. An out-of-range index matches no counter, so READ yields 0
  // and CLEAR_ONE touches nothing, without any separate range check.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_sel      = '0;
    addr_onehot = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        rd_sel         = shadow[i];
        addr_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      clr_vec[i] = (do_clr_one & clr_mask_q[i]) |
                   (do_sweep & (idx == ADDR_W'(i)));
    end
  end

  // ---------------------------------------------------------------------------
  // Host-side command registers, read data and sweep index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= CMD_READ;
      addr_q     <= '0;
      clr_mask_q <= '0;
      rd_pend    <= '0;
      rdata      <= '0;
      idx        <= '0;
    end else begin
      if (latch_cmd) begin
        cmd_q  <= cmd_e'(cmd);
        addr_q <= addr;
      end
      if (do_setup) begin
        rd_pend    <= rd_sel;
        clr_mask_q <= addr_onehot;
      end
      if (do_read) begin
        rdata <= rd_pend;
      end
      if (sweep_start) begin
        idx <= '0;
      end else if (do_sweep) begin
        // Return to 0 after the last counter so a non-power-of-two bank
        // leaves idx in a clean state.
        idx <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter and shadow banks. A clear on the same edge as an increment wins,
  // and that event is lost. The shadow copy takes the pre-increment value
  // because it samples count before this edge's update.
  // ---------------------------------------------------------------------------
`ifdef PERF_SATURATE_EN
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        count[i]  <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clr_vec[i]) begin
          count[i] <= '0;
        end else if (rise_q[i]) begin
`ifdef PERF_SATURATE_EN
          if (count[i] != CNT_MAX) begin
            count[i] <= count[i] + WIDTH'(1);
          end
`else
          count[i] <= count[i] + WIDTH'(1);
`endif
        end
        if (do_snap) begin
          shadow[i] <= count[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flags
  // ---------------------------------------------------------------------------
`ifdef PERF_SATURATE_EN
  logic [NUM_EVENTS-1:0] ovf_q;

  // An ovf bit is set by an increment attempt at full scale. It drops only when
  // that counter is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clr_vec[i]) begin
          ovf_q[i] <= 1'b0;
        end else if (rise_q[i] && (count[i] == CNT_MAX)) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl. A main 4-counter instance is paired
// with a 3-counter instance that shares the host port and checks the
// out-of-range READ.
module tb_perf_counter_ctrl;

  localparam int NE = 4;
  localparam int W  = 10;
  localparam int AW = 2;

  localparam logic [1:0] C_READ = 2'b00;
  localparam logic [1:0] C_SNAP = 2'b01;
  localparam logic [1:0] C_CLR1 = 2'b10;
  localparam logic [1:0] C_CLRA = 2'b11;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          count_en = 1'b0;
  logic          req      = 1'b0;
  logic [1:0]    cmd      = 2'b00;
  logic [AW-1:0] addr     = '0;
  logic [NE-1:0] event_in = '0;

  logic          ack;
  logic          busy;
  logic [W-1:0]  rdata;
  logic [NE-1:0] ovf;

  logic          ack3;
  logic          busy3;
  logic [W-1:0]  rdata3;
  logic [2:0]    ovf3;

  int nchk  = 0;
  int npass = 0;

  // event_in values driven before edges k..k+8 of the CLEAR_ALL test
  logic [3:0] ev_seq [0:8] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0};

  perf_counter_ctrl #(.NUM_EVENTS(NE), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .count_en(count_en),
    .req(req), .cmd(cmd), .addr(addr),
    .ack(ack), .busy(busy), .rdata(rdata), .ovf(ovf)
  );

  perf_counter_ctrl #(.NUM_EVENTS(3), .WIDTH(W), .ADDR_W(AW)) dut3 (
    .clk(clk), .reset(reset), .event_in(event_in[2:0]), .count_en(count_en),
    .req(req), .cmd(cmd), .addr(addr),
    .ack(ack3), .busy(busy3), .rdata(rdata3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full four-phase handshake with a bounded wait for ack.
  task automatic do_cmd(input logic [1:0] c, input logic [AW-1:0] a);
    int n;
    req  = 1'b1;
    cmd  = c;
    addr = a;
    n    = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 20);
    check("ack_seen", ack, 1);
    req = 1'b0;
    tick();
    check("ack_drop", ack, 0);
  endtask

  task automatic check_cnt(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    do_cmd(C_SNAP, a);
    do_cmd(C_READ, a);
    check(tag, rdata, exp);
  endtask

  task automatic pulse(input int i, input int n);
    for (int p = 0; p < n; p++) begin
      event_in[i] = 1'b1;
      tick();
      event_in[i] = 1'b0;
      tick();
    end
  endtask

  initial begin
    // ---- reset state
    #12;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ovf3", ovf3, 0);
    tick();
    reset    = 1'b1;
    count_en = 1'b1;
    tick();

    // ---- 5 pulses, snapshot, then READ with exact handshake timing
    pulse(0, 5);
    do_cmd(C_SNAP, 0);
    req  = 1'b1;
    cmd  = C_READ;
    addr = 0;
    tick();                                   // edge k
    check("rd_busy_k", busy, 1);
    check("rd_ack_k", ack, 0);
    tick();                                   // edge k+1
    check("rd_ack_k1", ack, 0);
    check("rd_busy_k1", busy, 1);
    tick();                                   // edge k+2
    check("rd_ack_k2", ack, 1);
    check("rd_data5", rdata, 5);
    req = 1'b0;
    tick();
    check("rd_ack_drop", ack, 0);
    check("rd_busy_drop", busy, 0);
    check("rd_data_hold", rdata, 5);
    tick();

    // ---- level held high counts once; edges with count_en low are dropped
    event_in[1] = 1'b1;
    repeat (20) tick();
    event_in[1] = 1'b0;
    tick();
    count_en = 1'b0;
    pulse(1, 3);
    count_en = 1'b1;
    tick();
    check_cnt("ev1_level", 1, 1);
    check_cnt("ev0_keep", 0, 5);

    // ---- READ returns the snapshot, not the live count
    do_cmd(C_SNAP, 0);
    pulse(0, 4);
    do_cmd(C_READ, 0);
    check("snap_old", rdata, 5);
    check_cnt("snap_new", 0, 9);

    // ---- CLEAR_ALL sweep with events racing the per-counter clears
    for (int j = 0; j <= 8; j++) begin
      event_in = ev_seq[j];
      if (j == 0) begin
        req = 1'b1;
        cmd = C_CLRA;
      end
      tick();                                 // edge k+j
      if (j == 0) check("ca_busy_k", busy, 1);
      if (j == 5) check("ca_ack_k5", ack, 0);
      if (j == 6) begin
        check("ca_ack_k6", ack, 1);
        req = 1'b0;
      end
      if (j == 7) begin
        check("ca_ack_drop", ack, 0);
        check("ca_busy_drop", busy, 0);
      end
    end
    tick();
    check_cnt("ca_cnt0", 0, 1);
    check_cnt("ca_cnt1", 1, 0);
    check_cnt("ca_cnt2", 2, 0);
    check_cnt("ca_cnt3", 3, 1);

    // ---- overflow on counter 2
    pulse(2, 1025);
    tick();
`ifdef PERF_SATURATE_EN
    check_cnt("ovf_cnt", 2, 1023);
    check("ovf_flag", ovf, 4'b0100);
`else
    check_cnt("wrap_cnt", 2, 1);
    check("ovf_zero", ovf, 0);
`endif
    do_cmd(C_CLR1, 2);
    check("clr1_ovf", ovf, 0);
    check_cnt("clr1_cnt2", 2, 0);
    check_cnt("clr1_cnt0", 0, 1);

    // ---- out-of-range READ on the 3-counter instance
    req  = 1'b1;
    cmd  = C_READ;
    addr = 2'd3;
    tick();
    tick();
    tick();
    check("oor_ack3", ack3, 1);
    check("oor_rdata3", rdata3, 0);
    check("oor_main", rdata, 1);
    req = 1'b0;
    tick();
    check("oor_drop3", ack3, 0);
    check("oor_busy3", busy3, 0);
    tick();

    // ---- reset in the middle of a sweep
    req = 1'b1;
    cmd = C_CLRA;
    repeat (4) tick();
    check("sw_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("sw_rst_ack", ack, 0);
    check("sw_rst_busy", busy, 0);
    check("sw_rst_rdata", rdata, 0);
    check("sw_rst_ovf", ovf, 0);
    check("sw_rst_rdata3", rdata3, 0);
    req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ack", ack, 0);
    check("post_rst_busy", busy, 0);
    check_cnt("post_rst_cnt0", 0, 0);
    check_cnt("post_rst_cnt3", 3, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
